fir_stream_ctrl: RTL and testbench

//   Valid/ready stream controller that sequences the 4-stage stall-all pipelined FIR
//   (fir_ena / fir_data_in / fir_data_out).
//   - Advances the FIR only when a real sample is accepted or a flush sample is injected.
//   - Tracks which pipeline slots hold valid results and presents them downstream with backpressure.
//   - Sits between the sample source and the FIR consumer; provides an end-of-stream flush.

---
 rtl/fir_stream_ctrl.sv | 160 ++++++++++++++++
 tb/tb_fir_stream_ctrl.sv | 393 +++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/fir_stream_ctrl.sv
`timescale 1ns/1ps
// ---------------------------------------------------------------------------
// fir_stream_ctrl
//
// Valid/ready stream controller for a 4-stage stall-all pipelined FIR.
// The FIR only advances (fir_ena) when a real sample is accepted or when a
// flush zero is injected. A valid-tag shift register mirrors the FIR
// pipeline, so the controller knows which FIR output is a real result.
// Results are presented downstream with backpressure.
//
// Handshake semantics (both stream ports): a transfer happens on a rising
// clk edge where valid and ready are both high. The producer holds valid
// and data stable until that transfer. Here s_ready and m_valid never
// depend on s_valid. s_ready does depend combinationally on m_ready and
// flush_req.
//
// Optional feature macro: FIR_CTRL_TAIL_EN
//   defined   : the flush also emits the N_TAPS-1 filter tail outputs
//   undefined : the flush only drains results that are already in flight
//
// Ports
//   clk, reset    clock (rising edge); asynchronous active-high reset
//   s_valid/s_ready/s_data   sample input stream (signed)
//   m_valid/m_ready/m_data   result output stream (m_data = fir_data_out)
//   flush_req     single-cycle request to drain the pipeline
//   flush_done    one-cycle pulse when the flush is complete
//   busy          high whenever the controller is not in RUN
//   out_count     number of results delivered; wraps around
//   fir_ena, fir_data_in, fir_data_out   FIR control and data
//   dbg_state     current FSM state (0=RUN, 1=FLUSH, 2=DONE)
// ---------------------------------------------------------------------------
module fir_stream_ctrl #(
    parameter int DATA_WIDTH = 18,
    parameter int OUT_WIDTH  = 38,
    parameter int LATENCY    = 4,
    parameter int N_TAPS     = 4,
    parameter int CNT_WIDTH  = 16
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  s_valid,
    output logic                  s_ready,
    input  logic [DATA_WIDTH-1:0] s_data,
    output logic                  m_valid,
    input  logic                  m_ready,
    output logic [OUT_WIDTH-1:0]  m_data,
    input  logic                  flush_req,
    output logic                  flush_done,
    output logic                  busy,
    output logic [CNT_WIDTH-1:0]  out_count,
    output logic                  fir_ena,
    output logic [DATA_WIDTH-1:0] fir_data_in,
    input  logic [OUT_WIDTH-1:0]  fir_data_out,
    output logic [1:0]            dbg_state
);

`ifdef FIR_CTRL_TAIL_EN
    localparam bit TAIL_EN = 1'b1;
`else
    localparam bit TAIL_EN = 1'b0;
`endif

    localparam int TAIL_LEN = N_TAPS - 1;
    // The LATENCY zeros always injected clear the FIR history and push
    // every in-flight result out. The tail zeros come on top of them.
    localparam int INJ_MAX  = LATENCY + (TAIL_EN ? TAIL_LEN : 0);
    localparam int INJ_W    = $clog2(INJ_MAX + 1);

    typedef enum logic [1:0] {
        ST_RUN   = 2'd0,
        ST_FLUSH = 2'd1,
        ST_DONE  = 2'd2
    } state_t;

    state_t             state;
    state_t             state_next;
    logic [LATENCY-1:0] vtag;
    logic [INJ_W-1:0]   inj;
    logic [INJ_W-1:0]   inj_next;
    logic               tag_in;
    logic               adv_ok;
    logic               inj_room;
    logic               m_fire;

    assign m_valid   = vtag[LATENCY-1];
    assign m_data    = fir_data_out;
    assign m_fire    = m_valid & m_ready;
    // The pipeline may only advance if the presented result is taken in the
    // same edge, or if no result is being presented.
    assign adv_ok    = !vtag[LATENCY-1] | m_ready;
    assign inj_room  = inj < INJ_W'(INJ_MAX);
    assign busy      = (state != ST_RUN);
    assign dbg_state = state;

    always_comb begin
        state_next  = state;
        inj_next    = inj;
        s_ready     = 1'b0;
        fir_ena     = 1'b0;
        fir_data_in = '0;
        tag_in      = 1'b0;
        flush_done  = 1'b0;
        case (state)
            ST_RUN: begin
                // The reset term keeps the input closed while reset is held.
                // Without it, the combinational ready would leak through.
                s_ready     = adv_ok & !flush_req & !reset;
                fir_ena     = s_valid & s_ready;
                fir_data_in = reset ? '0 : s_data;
                tag_in      = 1'b1;
                inj_next    = '0;
                if (flush_req) begin
                    state_next = ST_FLUSH;
                end
            end
            ST_FLUSH: begin
                fir_ena = adv_ok & inj_room;
                // The first TAIL_LEN zeros produce the tail outputs. Later
                // zeros only clear the FIR and drain it.
                tag_in  = TAIL_EN && (inj < INJ_W'(TAIL_LEN));
                if (fir_ena) begin
                    inj_next = inj + INJ_W'(1);
                end
                if (!inj_room && (vtag == '0)) begin
                    state_next = ST_DONE;
                end
            end
            ST_DONE: begin
                flush_done = 1'b1;
                state_next = ST_RUN;
            end
            default: begin
                state_next = ST_RUN;
            end
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state     <= ST_RUN;
            vtag      <= '0;
            inj       <= '0;
            out_count <= '0;
        end else begin
            state <= state_next;
            inj   <= inj_next;
            // A shift already moves the consumed top tag out, so a handshake
            // in the same edge needs no extra clear.
            if (fir_ena) begin
                vtag <= {vtag[LATENCY-2:0], tag_in};
            end else if (m_fire) begin
                vtag[LATENCY-1] <= 1'b0;
            end
            if (m_fire) begin
                out_count <= out_count + CNT_WIDTH'(1);
            end
        end
    end

endmodule

// File: tb/tb_fir_stream_ctrl.sv
`timescale 1ns/1ps
// Testbench for fir_stream_ctrl. The bench contains a behavioural
// 4-stage stall-all FIR (coefficients 10,20,30,40) that drives fir_data_out.
// A convolution reference model built from the fed sample stream supplies
// the expected results.
module tb_fir_stream_ctrl;

    localparam int DW  = 18;
    localparam int OW  = 38;
    localparam int CW  = 16;
    localparam int LAT = 4;
    localparam int NT  = 4;
`ifdef FIR_CTRL_TAIL_EN
    localparam bit TAIL_EN = 1'b1;
`else
    localparam bit TAIL_EN = 1'b0;
`endif
    localparam int TAIL = TAIL_EN ? NT - 1 : 0;

    logic          clk;
    logic          reset;
    logic          s_valid;
    logic          s_ready;
    logic [DW-1:0] s_data;
    logic          m_valid;
    logic          m_ready;
    logic [OW-1:0] m_data;
    logic          flush_req;
    logic          flush_done;
    logic          busy;
    logic [CW-1:0] out_count;
    logic          fir_ena;
    logic [DW-1:0] fir_data_in;
    logic [OW-1:0] fir_data_out;
    logic [1:0]    dbg_state;

    fir_stream_ctrl #(
        .DATA_WIDTH(DW), .OUT_WIDTH(OW), .LATENCY(LAT), .N_TAPS(NT), .CNT_WIDTH(CW)
    ) dut (
        .clk(clk), .reset(reset),
        .s_valid(s_valid), .s_ready(s_ready), .s_data(s_data),
        .m_valid(m_valid), .m_ready(m_ready), .m_data(m_data),
        .flush_req(flush_req), .flush_done(flush_done), .busy(busy),
        .out_count(out_count), .fir_ena(fir_ena), .fir_data_in(fir_data_in),
        .fir_data_out(fir_data_out), .dbg_state(dbg_state)
    );

    // ---------------- clock / reset ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ---------------- behavioural FIR (environment) ----------------
    logic signed [DW-1:0] fh0, fh1, fh2;
    logic [OW-1:0]        p0, p1, p2;

    always @(posedge clk or posedge reset) begin
        if (reset) begin
            fh0 <= '0; fh1 <= '0; fh2 <= '0;
            p0 <= '0; p1 <= '0; p2 <= '0; fir_data_out <= '0;
        end else if (fir_ena) begin
            p0 <= OW'(longint'($signed(fir_data_in)) * 10 + longint'(fh0) * 20 +
                      longint'(fh1) * 30 + longint'(fh2) * 40);
            fh0 <= $signed(fir_data_in);
            fh1 <= fh0;
            fh2 <= fh1;
            p1 <= p0;
            p2 <= p1;
            fir_data_out <= p2;
        end
    end

    // ---------------- reference model / scoreboard ----------------
    int            checks = 0;
    int            errors = 0;
    logic [OW-1:0] exp_q[$];
    logic [OW-1:0] obs_q[$];
    longint        stream_q[$];
    int            coef[NT] = '{10, 20, 30, 40};
    int            n_out = 0;
    int            done_pulses = 0;
    int            flush_starts = 0;
    bit            prev_hold = 1'b0;
    logic [OW-1:0] prev_data;
    logic [OW-1:0] mon_exp;

    // Output of the convolution for the newest sample in the fed stream.
    function automatic logic [OW-1:0] ref_out();
        longint acc;
        int     n;
        acc = 0;
        n   = stream_q.size();
        for (int i = 0; i < NT; i++) begin
            if (n - 1 - i >= 0) acc += longint'(coef[i]) * stream_q[n - 1 - i];
        end
        return acc[OW-1:0];
    endfunction

    task automatic clear_model();
        exp_q.delete();
        obs_q.delete();
        stream_q.delete();
        n_out        = 0;
        done_pulses  = 0;
        flush_starts = 0;
        prev_hold    = 1'b0;
    endtask

    always @(negedge clk) begin
        if (!reset) begin
            if (m_valid && m_ready) begin
                checks++;
                if (exp_q.size() == 0) begin
                    errors++;
                    $display("FAIL out_unexpected: got m_data=%0d, required no output", $signed(m_data));
                end else begin
                    mon_exp = exp_q.pop_front();
                    if (m_data !== mon_exp) begin
                        errors++;
                        $display("FAIL out_data: got %0d, required %0d", $signed(m_data), $signed(mon_exp));
                    end
                end
                obs_q.push_back(m_data);
                n_out++;
            end
            if (fir_ena) begin
                checks++;
                if (m_valid && !m_ready) begin
                    errors++;
                    $display("FAIL overwrite: got fir_ena=1 with stalled result, required 0");
                end
            end
            if (prev_hold) begin
                checks++;
                if (m_valid !== 1'b1 || m_data !== prev_data) begin
                    errors++;
                    $display("FAIL hold: got m_valid=%0b m_data=%0d, required 1 / %0d",
                             m_valid, $signed(m_data), $signed(prev_data));
                end
            end
            prev_hold = m_valid && !m_ready;
            prev_data = m_data;
            if (s_valid && s_ready) begin
                stream_q.push_back(longint'($signed(s_data)));
                exp_q.push_back(ref_out());
            end
            if (flush_req && !busy) begin
                flush_starts++;
                for (int i = 0; i < LAT + TAIL; i++) begin
                    stream_q.push_back(0);
                    if (i < TAIL) exp_q.push_back(ref_out());
                end
            end
            if (flush_done) done_pulses++;
        end
    end

    // ---------------- driver tasks ----------------
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic run_flush(output int cyc);
        int start;
        start     = done_pulses;
        flush_req = 1'b1;
        step();
        flush_req = 1'b0;
        cyc = 0;
        while (done_pulses == start && cyc < 300) begin
            step();
            cyc++;
        end
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        reset = 1'b1; s_valid = 1'b1; s_data = 18'h01234; m_ready = 1'b1; flush_req = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        checks++; if (s_ready !== 1'b0) begin errors++; $display("FAIL rst_s_ready: got %0b, required 0", s_ready); end
        checks++; if (m_valid !== 1'b0) begin errors++; $display("FAIL rst_m_valid: got %0b, required 0", m_valid); end
        checks++; if (flush_done !== 1'b0) begin errors++; $display("FAIL rst_flush_done: got %0b, required 0", flush_done); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL rst_busy: got %0b, required 0", busy); end
        checks++; if (out_count !== '0) begin errors++; $display("FAIL rst_out_count: got %0d, required 0", out_count); end
        checks++; if (fir_ena !== 1'b0) begin errors++; $display("FAIL rst_fir_ena: got %0b, required 0", fir_ena); end
        checks++; if (fir_data_in !== '0) begin errors++; $display("FAIL rst_fir_data_in: got %0d, required 0", fir_data_in); end
        checks++; if (dbg_state !== 2'd0) begin errors++; $display("FAIL rst_state: got %0d, required 0", dbg_state); end
        step();
        s_valid = 1'b0; s_data = '0; reset = 1'b0;
        clear_model();
        step();
    endtask

    task automatic test_impulse();
        int cyc;
        m_ready = 1'b1;
        for (int i = 0; i < 7; i++) begin
            s_valid = 1'b1;
            s_data  = (i == 0) ? DW'(1) : DW'(0);
            @(negedge clk);
            checks++; if (s_ready !== 1'b1) begin errors++; $display("FAIL imp_s_ready: got %0b, required 1", s_ready); end
            if (i == 3) begin
                checks++; if (m_valid !== 1'b0) begin errors++; $display("FAIL imp_early: got m_valid=%0b, required 0", m_valid); end
            end
            if (i == 4) begin
                checks++;
                if (m_valid !== 1'b1 || m_data !== OW'(10)) begin
                    errors++; $display("FAIL imp_first: got %0b/%0d, required 1/10", m_valid, $signed(m_data));
                end
            end
            step();
        end
        s_valid = 1'b0;
        run_flush(cyc);
        checks++; if (cyc >= 300) begin errors++; $display("FAIL imp_flush_timeout: got %0d cycles, required <300", cyc); end
        checks++; if (out_count !== CW'(n_out) || n_out != 7 + TAIL) begin
            errors++; $display("FAIL imp_count: got %0d (seen %0d), required %0d", out_count, n_out, 7 + TAIL);
        end
    endtask

    task automatic test_backpressure();
        int cyc;
        logic [OW-1:0] held;
        m_ready = 1'b0; s_valid = 1'b1; s_data = DW'($urandom);
        cyc = 0;
        while (!m_valid && cyc < 20) begin
            step();
            s_data = DW'($urandom);
            cyc++;
        end
        checks++; if (cyc >= 20) begin errors++; $display("FAIL bp_timeout: got %0d cycles, required <20", cyc); end
        held = m_data;
        repeat (5) begin
            @(negedge clk);
            checks++;
            if (s_ready !== 1'b0 || fir_ena !== 1'b0 || m_valid !== 1'b1 || m_data !== held) begin
                errors++;
                $display("FAIL bp_stall: got s_ready=%0b fir_ena=%0b m_valid=%0b m_data=%0d, required 0/0/1/%0d",
                         s_ready, fir_ena, m_valid, $signed(m_data), $signed(held));
            end
            step();
        end
        m_ready = 1'b1;
        repeat (6) begin
            s_valid = ($urandom_range(0, 1) == 1);
            s_data  = DW'($urandom);
            step();
        end
        s_valid = 1'b0;
        run_flush(cyc);
        checks++; if (cyc >= 300) begin errors++; $display("FAIL bp_flush_timeout: got %0d, required <300", cyc); end
        checks++; if (exp_q.size() != 0) begin errors++; $display("FAIL bp_missing: got %0d pending, required 0", exp_q.size()); end
        checks++; if (out_count !== CW'(n_out)) begin errors++; $display("FAIL bp_count: got %0d, required %0d", out_count, CW'(n_out)); end
    endtask

    task automatic test_flush_values(input string name, input logic [DW-1:0] first_sample, input int n_samples);
        int cyc;
        int start;
        logic [OW-1:0] want[$];
        want.delete();
        if (first_sample == DW'(5)) begin
            want.push_back(OW'(50)); want.push_back(OW'(100)); want.push_back(OW'(150));
            if (TAIL_EN) begin want.push_back(OW'(200)); want.push_back(OW'(0)); want.push_back(OW'(0)); end
        end else begin
            want.push_back(OW'(10));
            if (TAIL_EN) begin want.push_back(OW'(20)); want.push_back(OW'(30)); want.push_back(OW'(40)); end
        end
        obs_q.delete();
        m_ready = 1'b1;
        start = done_pulses;
        for (int i = 0; i < n_samples; i++) begin
            s_valid = 1'b1;
            s_data  = (i == 0) ? first_sample : DW'(0);
            step();
        end
        s_valid = 1'b0;
        run_flush(cyc);
        checks++; if (cyc >= 300) begin errors++; $display("FAIL %s_timeout: got %0d, required <300", name, cyc); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL %s_busy: got %0b, required 0", name, busy); end
        repeat (3) step();
        checks++; if (done_pulses != start + 1) begin errors++; $display("FAIL %s_done_pulses: got %0d, required 1", name, done_pulses - start); end
        checks++;
        if (obs_q.size() != want.size()) begin
            errors++; $display("FAIL %s_len: got %0d outputs, required %0d", name, obs_q.size(), want.size());
        end else begin
            for (int i = 0; i < want.size(); i++) begin
                checks++;
                if (obs_q[i] !== want[i]) begin
                    errors++; $display("FAIL %s_val%0d: got %0d, required %0d", name, i, $signed(obs_q[i]), $signed(want[i]));
                end
            end
        end
    endtask

    task automatic test_flush_conflict();
        int start;
        int cyc;
        m_ready = 1'b1; start = done_pulses;
        s_valid = 1'b1; s_data = DW'(7); flush_req = 1'b1;
        @(negedge clk);
        checks++; if (s_ready !== 1'b0 || fir_ena !== 1'b0) begin
            errors++; $display("FAIL conf_accept: got s_ready=%0b fir_ena=%0b, required 0/0", s_ready, fir_ena);
        end
        step();
        checks++; if (busy !== 1'b1 || dbg_state !== 2'd1) begin
            errors++; $display("FAIL conf_enter: got busy=%0b state=%0d, required 1/1", busy, dbg_state);
        end
        flush_req = 1'b1;
        step();
        flush_req = 1'b0; s_valid = 1'b0;
        cyc = 0;
        while (done_pulses == start && cyc < 100) begin step(); cyc++; end
        checks++; if (cyc >= 100) begin errors++; $display("FAIL conf_timeout: got %0d, required <100", cyc); end
        repeat (10) step();
        checks++; if (done_pulses != start + 1 || busy !== 1'b0) begin
            errors++; $display("FAIL conf_reflush: got pulses=%0d busy=%0b, required 1/0", done_pulses - start, busy);
        end
        checks++; if (exp_q.size() != 0) begin errors++; $display("FAIL conf_pending: got %0d, required 0", exp_q.size()); end
    endtask

    task automatic test_reset_mid_flush();
        int cyc;
        m_ready = 1'b0; s_valid = 1'b1; s_data = DW'($urandom);
        cyc = 0;
        while (!m_valid && cyc < 20) begin step(); s_data = DW'($urandom); cyc++; end
        s_valid = 1'b0; flush_req = 1'b1;
        step();
        flush_req = 1'b0;
        checks++; if (busy !== 1'b1 || m_valid !== 1'b1 || out_count == '0) begin
            errors++; $display("FAIL mid_setup: got busy=%0b m_valid=%0b cnt=%0d, required 1/1/nonzero", busy, m_valid, out_count);
        end
        #1 reset = 1'b1;
        #1;
        checks++; if (m_valid !== 1'b0) begin errors++; $display("FAIL mid_m_valid: got %0b, required 0", m_valid); end
        checks++; if (dbg_state !== 2'd0 || busy !== 1'b0) begin
            errors++; $display("FAIL mid_state: got %0d/%0b, required 0/0", dbg_state, busy);
        end
        checks++; if (out_count !== '0) begin errors++; $display("FAIL mid_count: got %0d, required 0", out_count); end
        checks++; if (fir_ena !== 1'b0 || flush_done !== 1'b0) begin
            errors++; $display("FAIL mid_outs: got fir_ena=%0b flush_done=%0b, required 0/0", fir_ena, flush_done);
        end
        clear_model();
        step();
        reset = 1'b0;
        step();
    endtask

    task automatic test_random();
        int cyc;
        for (int c = 0; c < 400; c++) begin
            s_valid   = ($urandom_range(0, 3) != 0);
            s_data    = DW'($urandom);
            m_ready   = ($urandom_range(0, 3) != 0);
            flush_req = (!busy && $urandom_range(0, 49) == 0);
            step();
        end
        s_valid = 1'b0; flush_req = 1'b0; m_ready = 1'b1;
        cyc = 0;
        while (busy && cyc < 100) begin step(); cyc++; end
        run_flush(cyc);
        checks++; if (cyc >= 300) begin errors++; $display("FAIL rnd_timeout: got %0d, required <300", cyc); end
        checks++; if (exp_q.size() != 0) begin errors++; $display("FAIL rnd_missing: got %0d pending, required 0", exp_q.size()); end
        checks++; if (out_count !== CW'(n_out)) begin errors++; $display("FAIL rnd_count: got %0d, required %0d", out_count, CW'(n_out)); end
        checks++; if (done_pulses != flush_starts) begin
            errors++; $display("FAIL rnd_done: got %0d pulses, required %0d", done_pulses, flush_starts);
        end
    endtask

    // ---------------- sequence and report ----------------
    initial begin
        reset = 1'b1; s_valid = 1'b0; s_data = '0; m_ready = 1'b0; flush_req = 1'b0;
        test_reset();
        test_impulse();
        test_backpressure();
        test_flush_values("flush5", DW'(5), 3);
        test_flush_values("tail1", DW'(1), 1);
        test_flush_conflict();
        test_reset_mid_flush();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #1000000;
        errors++;
        $display("FAIL watchdog: got timeout at %0t, required completion", $time);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $fatal(1);
    end

endmodule
